// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: PC register drives the ROM, fetched words queue up for decode.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
module instr_fetch_ctrl #(
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int unsigned ROM_WORDS = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en_i,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        fault_o
);

  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam logic [PtrW:0] Full   = (PtrW + 1)'(DEPTH);
  localparam logic [31:0] RomLimit = 32'(ROM_WORDS * 4);
  localparam logic [31:0] NopInst  = 32'h0000_0013;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {StBoot, StRun, StFault} state_e;
`else
  typedef enum logic [0:0] {StBoot, StRun} state_e;
`endif

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]     count_q, count_d;
  logic [31:0]       mem_inst_q [DEPTH];
  logic [31:0]       mem_pc_q [DEPTH];
  logic [31:0]       head_inst_q, head_inst_d;
  logic [31:0]       head_pc_q, head_pc_d;
  logic              pop, push, redirect_ok, remaining_nz;
  logic [31:0]       push_word;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic              fault_q, fault_d;
`endif

  assign pop       = (count_q != '0) && inst_ready_i;
  assign push_word = (pc_q < RomLimit) ? rom_data_i : NopInst;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    head_inst_d  = head_inst_q;
    head_pc_d    = head_pc_q;
    push         = 1'b0;
    remaining_nz = 1'b0;
    redirect_ok  = redirect_i;
`ifdef FETCH_MISALIGN_TRAP_EN
    fault_d      = fault_q;
    if (state_q == StFault) redirect_ok = 1'b0;
`endif

    case (state_q)
      StBoot:  state_d = StRun;
      default: ;
    endcase

    if (redirect_ok) begin
      // Flush wins over push and pop; head registers keep the last delivered entry.
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      pc_d     = redirect_pc_i & ~32'h3;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_pc_i[1:0] != 2'b00) begin
        fault_d = 1'b1;
        state_d = StFault;
      end
`endif
    end else begin
      push = (state_q == StRun) && fetch_en_i && ((count_q != Full) || pop);
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        pc_d     = pc_q + 32'd4;
      end
      if (push && !pop) count_d = count_q + (PtrW + 1)'(1);
      else if (pop && !push) count_d = count_q - (PtrW + 1)'(1);

      remaining_nz = pop ? (count_q > (PtrW + 1)'(1)) : (count_q != '0);
      if (remaining_nz) begin
        head_inst_d = mem_inst_q[rd_ptr_d];
        head_pc_d   = mem_pc_q[rd_ptr_d];
      end else if (push) begin
        head_inst_d = push_word;
        head_pc_d   = pc_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StBoot;
      pc_q        <= RESET_PC;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      head_inst_q <= '0;
      head_pc_q   <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      head_inst_q <= head_inst_d;
      head_pc_q   <= head_pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q     <= fault_d;
`endif
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst_q[wr_ptr_q] <= push_word;
      mem_pc_q[wr_ptr_q]   <= pc_q;
    end
  end

  assign rom_addr_o   = pc_q;
  assign inst_valid_o = (count_q != '0);
  assign inst_o       = head_inst_q;
  assign inst_pc_o    = head_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign fault_o      = fault_q;
`else
  assign fault_o      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed-vector bench for instr_fetch_ctrl with DEPTH=2, ROM_WORDS=4.
module tb_instr_fetch_ctrl;

  localparam logic [31:0] R0  = 32'h0010_6093;
  localparam logic [31:0] R1  = 32'h00a1_2113;
  localparam logic [31:0] R2  = 32'h00a1_a193;
  localparam logic [31:0] R3  = 32'h00b2_2213;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, fetch_en, redirect, ready;
  logic [31:0] redirect_pc, rom_addr, rom_data, inst, inst_pc;
  logic        inst_valid, fault;
  logic [31:0] rom [8];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        en;
    logic        rdy;
    logic        red;
    logic [31:0] rpc;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs [23];

  instr_fetch_ctrl #(.DEPTH(2), .RESET_PC(32'h0), .ROM_WORDS(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_en_i   (fetch_en),
    .rom_addr_o   (rom_addr),
    .rom_data_i   (rom_data),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .inst_valid_o (inst_valid),
    .inst_ready_i (ready),
    .inst_o       (inst),
    .inst_pc_o    (inst_pc),
    .fault_o      (fault)
  );

  always #5 clk = ~clk;

  // Bench ROM is larger than ROM_WORDS so out-of-range reads return non-NOP data.
  always_comb rom_data = (rom_addr < 32'd32) ? rom[rom_addr[4:2]] : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic rdy, input logic red, input logic [31:0] rpc);
    fetch_en    = en;
    ready       = rdy;
    redirect    = red;
    redirect_pc = rpc;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rom[0] = R0; rom[1] = R1; rom[2] = R2; rom[3] = R3;
    rom[4] = 32'hAAAA_0004; rom[5] = 32'hAAAA_0005;
    rom[6] = 32'hAAAA_0006; rom[7] = 32'hAAAA_0007;

    //          en rdy red rpc            valid inst pc            addr
    vecs[0]  = '{1, 0, 0, 32'h0,          0, 32'h0, 32'h0,         32'h0};
    vecs[1]  = '{1, 0, 0, 32'h0,          1, R0,    32'h0,         32'h4};
    vecs[2]  = '{1, 0, 0, 32'h0,          1, R0,    32'h0,         32'h8};
    vecs[3]  = '{1, 0, 0, 32'h0,          1, R0,    32'h0,         32'h8};
    vecs[4]  = '{1, 0, 0, 32'h0,          1, R0,    32'h0,         32'h8};
    vecs[5]  = '{1, 1, 0, 32'h0,          1, R1,    32'h4,         32'hC};
    vecs[6]  = '{1, 1, 0, 32'h0,          1, R2,    32'h8,         32'h10};
    vecs[7]  = '{1, 1, 0, 32'h0,          1, R3,    32'hC,         32'h14};
    vecs[8]  = '{1, 1, 0, 32'h0,          1, NOP,   32'h10,        32'h18};
    vecs[9]  = '{1, 1, 0, 32'h0,          1, NOP,   32'h14,        32'h1C};
    vecs[10] = '{1, 1, 1, 32'h4,          0, NOP,   32'h14,        32'h4};
    vecs[11] = '{1, 1, 0, 32'h0,          1, R1,    32'h4,         32'h8};
    vecs[12] = '{0, 1, 0, 32'h0,          0, R1,    32'h4,         32'h8};
    vecs[13] = '{0, 1, 0, 32'h0,          0, R1,    32'h4,         32'h8};
    vecs[14] = '{1, 1, 0, 32'h0,          1, R2,    32'h8,         32'hC};
    vecs[15] = '{1, 1, 1, 32'h10,         0, R2,    32'h8,         32'h10};
    vecs[16] = '{1, 1, 1, 32'h8,          0, R2,    32'h8,         32'h8};
    vecs[17] = '{1, 1, 0, 32'h0,          1, R2,    32'h8,         32'hC};
    vecs[18] = '{1, 0, 0, 32'h0,          1, R2,    32'h8,         32'h10};
    vecs[19] = '{1, 0, 1, 32'hFFFF_FFFC,  0, R2,    32'h8,         32'hFFFF_FFFC};
    vecs[20] = '{1, 1, 0, 32'h0,          1, NOP,   32'hFFFF_FFFC, 32'h0};
    vecs[21] = '{1, 1, 0, 32'h0,          1, R0,    32'h0,         32'h4};
    vecs[22] = '{1, 0, 0, 32'h0,          1, R0,    32'h0,         32'h8};

    reset = 1'b1; fetch_en = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("reset_valid", 32'(inst_valid), 32'd0);
    check("reset_inst",  inst,            32'h0);
    check("reset_pc",    inst_pc,         32'h0);
    check("reset_addr",  rom_addr,        32'h0);
    check("reset_fault", 32'(fault),      32'd0);
    reset = 1'b0;

    for (int i = 0; i < 23; i++) begin
      step(vecs[i].en, vecs[i].rdy, vecs[i].red, vecs[i].rpc);
      check($sformatf("v%0d_valid", i), 32'(inst_valid), 32'(vecs[i].valid));
      check($sformatf("v%0d_addr", i),  rom_addr,        vecs[i].addr);
      check($sformatf("v%0d_fault", i), 32'(fault),      32'd0);
      if (vecs[i].valid) begin
        check($sformatf("v%0d_inst", i), inst,    vecs[i].inst);
        check($sformatf("v%0d_pc", i),   inst_pc, vecs[i].pc);
      end
    end

    // Reset with two entries in flight.
    reset = 1'b1;
    step(1, 0, 0, 32'h0);
    check("midreset_valid", 32'(inst_valid), 32'd0);
    check("midreset_addr",  rom_addr,        32'h0);
    check("midreset_pc",    inst_pc,         32'h0);
    reset = 1'b0;

    // Misaligned redirect.
    step(1, 1, 0, 32'h0);
    check("mis_boot_valid", 32'(inst_valid), 32'd0);
    step(1, 1, 0, 32'h0);
    check("mis_first_valid", 32'(inst_valid), 32'd1);
    check("mis_first_inst",  inst,            R0);
    step(1, 1, 1, 32'h22);
    check("mis_flush_valid", 32'(inst_valid), 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_fault_set", 32'(fault), 32'd1);
    step(1, 1, 0, 32'h0);
    check("mis_fault_valid", 32'(inst_valid), 32'd0);
    check("mis_fault_hold",  32'(fault),      32'd1);
    check("mis_fault_pc",    inst_pc,         32'h0);
    step(1, 1, 1, 32'h4);
    check("mis_fault_redir_valid", 32'(inst_valid), 32'd0);
    check("mis_fault_redir_fault", 32'(fault),      32'd1);
`else
    check("mis_addr",  rom_addr,   32'h20);
    check("mis_fault", 32'(fault), 32'd0);
    step(1, 1, 0, 32'h0);
    check("mis_next_valid", 32'(inst_valid), 32'd1);
    check("mis_next_pc",    inst_pc,         32'h20);
    check("mis_next_inst",  inst,            NOP);
    check("mis_next_addr",  rom_addr,        32'h24);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
